// File: rtl/test_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_seq_pkg
// Description : Shared types, constants and LFSR/MISR step helper for the
//               BIST sequencer of the 'test' datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package test_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Shift register width and feedback taps (x^16+x^14+x^13+x^11+1)
    localparam int LFSR_W = 16;
    localparam int TAP0   = 0;
    localparam int TAP1   = 2;
    localparam int TAP2   = 3;
    localparam int TAP3   = 5;

    // Response width from the 'test' datapath {h,i,j,l,m,n,o,p,q}
    localparam int RESP_W = 9;

    // Stimulus field offsets {a,b,c,d,e[3:0],f[3:0],g[3:0]}
    localparam int STIM_A    = 15;
    localparam int STIM_B    = 14;
    localparam int STIM_C    = 13;
    localparam int STIM_D    = 12;
    localparam int STIM_E_HI = 11;
    localparam int STIM_E_LO = 8;
    localparam int STIM_F_HI = 7;
    localparam int STIM_F_LO = 4;
    localparam int STIM_G_HI = 3;
    localparam int STIM_G_LO = 0;

    // One Fibonacci shift: feedback enters at the MSB, register shifts right
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[TAP0] ^ v[TAP1] ^ v[TAP2] ^ v[TAP3], v[LFSR_W-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/test_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : test_seq_if
// Description : Control, stimulus and response bundle between host/bench
//               (master) and the BIST sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface test_seq_if
    import test_seq_pkg::*;
#(
    parameter int VEC_W  = 16,
    parameter int HOLD_W = 4
);
    logic                start;
    logic                abort;
    logic [VEC_W-1:0]    num_vec;
    logic [HOLD_W-1:0]   hold_cyc;
    logic [15:0]         exp_sig;
    logic [15:0]         stim;
    logic [RESP_W-1:0]   resp;
    logic                busy;
    logic                done;
    logic                pass;
    logic [15:0]         sig;
    logic [VEC_W-1:0]    vec_idx;

    modport master (
        output start, abort, num_vec, hold_cyc, exp_sig, resp,
        input  stim, busy, done, pass, sig, vec_idx
    );

    modport slave (
        input  start, abort, num_vec, hold_cyc, exp_sig, resp,
        output stim, busy, done, pass, sig, vec_idx
    );
endinterface
`default_nettype wire

// File: rtl/test_seq_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : test_seq_lfsr16
// Description : 16-bit Fibonacci shift register with parallel XOR input.
//               din=0 gives a plain LFSR; din=response gives a MISR.
// Revision    : 1.0 - initial release
// ============================================================================
module test_seq_lfsr16
    import test_seq_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load_i,
    input  wire logic        step_i,
    input  wire logic [15:0] din_i,
    output logic      [15:0] q_o
);
    logic [15:0] val_q;
    logic [15:0] val_d;

    // Load has priority over step; otherwise hold
    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = SEED;
        end else if (step_i) begin
            val_d = lfsr_next(val_q) ^ din_i;
        end
    end

    // Register with asynchronous reset to the seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= SEED;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o = val_q;
endmodule
`default_nettype wire

// File: rtl/test_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : test_seq_ctrl
// Description : BIST sequencer. Applies LFSR vectors to the 'test' datapath,
//               holds each for a programmable settle time, compresses the
//               response in a MISR and compares against an expected signature.
// Revision    : 1.0 - initial release
// ============================================================================
module test_seq_ctrl
    import test_seq_pkg::*;
#(
    parameter int          VEC_W     = 16,
    parameter int          HOLD_W    = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  wire logic clk,
    input  wire logic rst,
    test_seq_if.slave bus
);
    state_t              state_q,   state_d;
    logic [HOLD_W-1:0]   cnt_q,     cnt_d;
    logic [HOLD_W-1:0]   hold_q,    hold_d;
    logic [VEC_W-1:0]    num_vec_q, num_vec_d;
    logic [VEC_W-1:0]    vec_idx_q, vec_idx_d;
    logic [15:0]         stim_q,    stim_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                pass_q,    pass_d;
    logic                zero_q,    zero_d;

    logic                lfsr_load;
    logic                lfsr_adv;
    logic                misr_load;
    logic                misr_adv;
    logic [15:0]         lfsr_val;
    logic [15:0]         misr_val;
    logic [VEC_W-1:0]    vec_inc;

    assign vec_inc = vec_idx_q + {{(VEC_W-1){1'b0}}, 1'b1};

    // Stimulus generator
    test_seq_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load),
        .step_i (lfsr_adv),
        .din_i  (16'h0000),
        .q_o    (lfsr_val)
    );

    // Response compressor
    test_seq_lfsr16 #(
        .SEED (16'h0000)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .load_i (misr_load),
        .step_i (misr_adv),
        .din_i  ({{(16-RESP_W){1'b0}}, bus.resp}),
        .q_o    (misr_val)
    );

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        num_vec_d = num_vec_q;
        vec_idx_d = vec_idx_q;
        stim_d    = stim_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        zero_d    = zero_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        misr_load = 1'b0;
        misr_adv  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    pass_d    = 1'b0;
                    vec_idx_d = '0;
                    misr_load = 1'b1;
                    if (bus.num_vec != '0) begin
                        num_vec_d = bus.num_vec;
                        hold_d    = bus.hold_cyc;
                        cnt_d     = bus.hold_cyc;
                        lfsr_load = 1'b1;
                        stim_d    = LFSR_SEED;
                        busy_d    = 1'b1;
                        state_d   = APPLY;
                    end else begin
                        // Zero-vector run: extra settle cycle in DONE keeps
                        // the done pulse two cycles after the start edge.
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            APPLY: begin
                if (bus.abort) begin
                    stim_d  = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end

            SAMPLE: begin
                if (bus.abort) begin
                    // Abort wins over the capture: signature keeps last value
                    stim_d  = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    misr_adv  = 1'b1;
                    vec_idx_d = vec_inc;
                    if (vec_inc == num_vec_q) begin
                        state_d = DONE;
                    end else begin
                        lfsr_adv = 1'b1;
                        stim_d   = lfsr_next(lfsr_val);
                        cnt_d    = hold_q;
                        state_d  = APPLY;
                    end
                end
            end

            DONE: begin
                if (zero_q) begin
                    zero_d = 1'b0;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    stim_d  = '0;
                    pass_d  = (misr_val == bus.exp_sig);
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            num_vec_q <= '0;
            vec_idx_q <= '0;
            stim_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            num_vec_q <= num_vec_d;
            vec_idx_q <= vec_idx_d;
            stim_q    <= stim_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.stim    = stim_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.sig     = misr_val;
    assign bus.vec_idx = vec_idx_q;
endmodule
`default_nettype wire
